// File: rtl/sayac_bus_pkg.sv
// sayac_bus_pkg
// Shared definitions for the SAYAC bus master sequencer and the cache bench:
// command op encodings, the sequencer FSM state type and a small op helper.
package sayac_bus_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RCHK  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_GAP
    } state_e;

    // Both READ and READ_CHECK have the upper op bit set.
    function automatic logic op_is_read(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/sayac_cmd_ram.sv
// sayac_cmd_ram
// Command store for the bus master: one write port, one registered read port.
// Contents are not reset.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  slot written
//   wdata  {op, adr, data} written
//   raddr  slot read
//   rdata  registered read data
module sayac_cmd_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 34,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write-first on a same-slot collision so a command written in the same
    // cycle as start is the one fetched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sayac_bus_master_seq.sv
// sayac_bus_master_seq
// Programmable bus master replaying a loaded command list of NOP / WRITE /
// READ / READ_CHECK accesses on the cache-side rd/wr/ready bus.
// Ports:
//   clk, rst                 clock, async active-low reset
//   cmd_we/idx/op/adr/data   command slot load (ignored while busy)
//   cmd_count, start         run length (clamped to CMD_DEPTH) and run trigger
//   busy, done               run in progress, one-cycle end-of-run pulse
//   timeout_err              sticky, last run aborted by the watchdog
//   mismatch_cnt             saturating READ_CHECK mismatch count
//   last_rdata               data of the most recent completed read
//   address_bus, data_bus    tristate bus, rd/wr strobes, ready handshake
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; slot 0 is being read ahead
// ST_FETCH | command of slot ptr available, latch it and decide
// ST_ISSUE | strobe held until ready or watchdog expiry
// ST_GAP   | one idle bus cycle, advance ptr, read ahead next slot
module sayac_bus_master_seq
    import sayac_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 16,
    parameter int CMD_DEPTH  = 32,
    parameter int TIMEOUT    = 255,
    localparam int CW = $clog2(CMD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_we,
    input  logic [CW-1:0]         cmd_idx,
    input  logic [1:0]            cmd_op,
    input  logic [ADR_WIDTH-1:0]  cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [CW:0]           cmd_count,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [15:0]           mismatch_cnt,
    output logic [DATA_WIDTH-1:0] last_rdata,
    output wire  [ADR_WIDTH-1:0]  address_bus,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  ready,
    output logic                  rd,
    output logic                  wr
);

    localparam int RW = 2 + ADR_WIDTH + DATA_WIDTH;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] DEPTH_N = (CW + 1)'(CMD_DEPTH);

    state_e                state;
    logic [CW:0]           n_cmds;
    logic [CW:0]           ptr;
    logic [CW:0]           ptr_inc;
    logic [CW:0]           cmd_n;
    op_e                   op_q;
    logic [ADR_WIDTH-1:0]  adr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [WW-1:0]         wd_cnt;

    logic                  ram_we;
    logic [CW-1:0]         ram_raddr;
    logic [RW-1:0]         ram_rdata;
    op_e                   ram_op;
    logic [ADR_WIDTH-1:0]  ram_adr;
    logic [DATA_WIDTH-1:0] ram_dat;

    assign ptr_inc = ptr + 1'b1;
    assign cmd_n   = (cmd_count > DEPTH_N) ? DEPTH_N : cmd_count;
    assign ram_we  = cmd_we && (state == ST_IDLE);
    assign ram_op  = op_e'(ram_rdata[RW-1 -: 2]);
    assign ram_adr = ram_rdata[DATA_WIDTH +: ADR_WIDTH];
    assign ram_dat = ram_rdata[DATA_WIDTH-1:0];

    // Read address runs one step ahead so the command is ready in FETCH.
    always_comb begin
        ram_raddr = ptr[CW-1:0];
        if (state == ST_IDLE) begin
            ram_raddr = '0;
        end else if (state == ST_GAP) begin
            ram_raddr = ptr_inc[CW-1:0];
        end
    end

    sayac_cmd_ram #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (RW)
    ) u_cmd_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cmd_idx),
        .wdata ({cmd_op, cmd_adr, cmd_data}),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign address_bus = (rd || wr) ? adr_q : 'z;
    assign data_bus    = wr ? data_q : 'z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            n_cmds       <= '0;
            ptr          <= '0;
            op_q         <= OP_NOP;
            adr_q        <= '0;
            data_q       <= '0;
            wd_cnt       <= '0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            mismatch_cnt <= '0;
            last_rdata   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_cmds       <= cmd_n;
                        ptr          <= '0;
                        mismatch_cnt <= '0;
                        timeout_err  <= 1'b0;
                        if (cmd_n == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    op_q   <= ram_op;
                    adr_q  <= ram_adr;
                    data_q <= ram_dat;
                    if (ram_op == OP_NOP) begin
                        state <= ST_GAP;
                    end else begin
                        rd     <= op_is_read(ram_op);
                        wr     <= (ram_op == OP_WRITE);
                        wd_cnt <= WW'(TIMEOUT - 1);
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ready) begin
                        rd    <= 1'b0;
                        wr    <= 1'b0;
                        state <= ST_GAP;
                        if (rd) begin
                            last_rdata <= data_bus;
                        end
                        if ((op_q == OP_RCHK) && (data_bus != data_q) &&
                            (mismatch_cnt != 16'hFFFF)) begin
                            mismatch_cnt <= mismatch_cnt + 16'd1;
                        end
                    end else if ((TIMEOUT != 0) && (wd_cnt == '0)) begin
                        // Strobe has been held TIMEOUT cycles: abandon the run.
                        rd          <= 1'b0;
                        wr          <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    ptr <= ptr_inc;
                    if (ptr_inc == n_cmds) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sayac_bus_master_seq.sv
// tb_sayac_bus_master_seq
// Directed bench for sayac_bus_master_seq. u_dut (TIMEOUT=0) talks to a
// memory-backed slave with programmable latency; u_dut_to (TIMEOUT=8) sees a
// slave that never answers.
module tb_sayac_bus_master_seq;
    import sayac_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_we = 1'b0;
    logic [4:0]  cmd_idx = '0;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_adr = '0;
    logic [15:0] cmd_data = '0;
    logic [5:0]  cmd_count = '0;
    logic        start = 1'b0;
    logic        start_a = 1'b0;

    logic        busy_b, done_b, terr_b, rd_b, wr_b;
    logic [15:0] mis_b, last_b;
    wire  [15:0] address_bus_b;
    wire  [15:0] data_bus_b;
    logic        ready_b;

    logic        busy_a, done_a, terr_a, rd_a, wr_a;
    logic [15:0] mis_a, last_a;
    wire  [15:0] address_bus_a;
    wire  [15:0] data_bus_a;

    int n_checks = 0;
    int n_errs   = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    sayac_bus_master_seq #(
        .DATA_WIDTH (16), .ADR_WIDTH (16), .CMD_DEPTH (32), .TIMEOUT (0)
    ) u_dut (
        .clk (clk), .rst (rst), .cmd_we (cmd_we), .cmd_idx (cmd_idx),
        .cmd_op (cmd_op), .cmd_adr (cmd_adr), .cmd_data (cmd_data),
        .cmd_count (cmd_count), .start (start), .busy (busy_b), .done (done_b),
        .timeout_err (terr_b), .mismatch_cnt (mis_b), .last_rdata (last_b),
        .address_bus (address_bus_b), .data_bus (data_bus_b),
        .ready (ready_b), .rd (rd_b), .wr (wr_b)
    );

    sayac_bus_master_seq #(
        .DATA_WIDTH (16), .ADR_WIDTH (16), .CMD_DEPTH (32), .TIMEOUT (8)
    ) u_dut_to (
        .clk (clk), .rst (rst), .cmd_we (cmd_we), .cmd_idx (cmd_idx),
        .cmd_op (cmd_op), .cmd_adr (cmd_adr), .cmd_data (cmd_data),
        .cmd_count (cmd_count), .start (start_a), .busy (busy_a), .done (done_a),
        .timeout_err (terr_a), .mismatch_cnt (mis_a), .last_rdata (last_a),
        .address_bus (address_bus_a), .data_bus (data_bus_a),
        .ready (1'b0), .rd (rd_a), .wr (wr_a)
    );

    // Slave for u_dut: ready rises lat_b cycles after the strobe, one cycle wide.
    logic [15:0] smem [64];
    logic        rand_lat = 1'b0;
    int          lat_b = 1;
    int          cnt_b = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_b <= 1'b0;
            cnt_b   <= 0;
            lat_b   <= 1;
        end else begin
            ready_b <= 1'b0;
            if ((rd_b || wr_b) && !ready_b) begin
                if (cnt_b + 1 >= lat_b) begin
                    ready_b <= 1'b1;
                    cnt_b   <= 0;
                    if (wr_b) smem[address_bus_b[5:0]] <= data_bus_b;
                    lat_b <= rand_lat ? int'($urandom_range(20, 1)) : 1;
                end else begin
                    cnt_b <= cnt_b + 1;
                end
            end
        end
    end

    assign data_bus_b = (rd_b && ready_b) ? smem[address_bus_b[5:0]] : 'z;

    always @(negedge clk) begin
        if ((rd_b && wr_b) || (rd_a && wr_a)) overlap++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_cmd(input int idx, input op_e op, input logic [15:0] adr, input logic [15:0] data);
        cmd_we   = 1'b1;
        cmd_idx  = 5'(idx);
        cmd_op   = op;
        cmd_adr  = adr;
        cmd_data = data;
        @(negedge clk);
        cmd_we   = 1'b0;
    endtask

    // Starts u_dut and follows it until busy falls; stops at negedge where busy
    // has fallen, so done should be visible right then.
    task automatic run_b(input int cnt, input int budget, input int poke_at,
                         output int cyc, output int acc, output int first_stb,
                         output logic done_seen);
        cmd_count = 6'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        acc = 0;
        first_stb = -1;
        while (busy_b && cyc < budget) begin
            if ((rd_b || wr_b) && first_stb < 0) first_stb = cyc;
            if ((rd_b || wr_b) && ready_b) acc++;
            cyc++;
            if (cyc == poke_at) begin
                start = 1'b1; cmd_we = 1'b1; cmd_idx = 5'd3; cmd_op = OP_RCHK;
                cmd_adr = 16'd11; cmd_data = 16'h0BAD;
            end else if (cyc == poke_at + 1) begin
                start = 1'b0; cmd_we = 1'b0;
            end
            @(negedge clk);
        end
        done_seen = done_b;
        if (cyc >= budget) check_val("run_budget_busy", busy_b, 0);
    endtask

    int cyc, acc, fst, k, rdc;
    logic dn;
    logic [15:0] model [64];
    logic [15:0] exp_last;
    int exp_mis;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_busy", busy_b, 0);
        check_val("rst_done", done_b, 0);
        check_val("rst_rd", rd_b, 0);
        check_val("rst_wr", wr_b, 0);
        check_val("rst_terr", terr_b, 0);
        check_val("rst_mis", mis_b, 0);
        check_val("rst_last", last_b, 0);

        // Basic list: one mismatch, last read 111, 4 cycles per access.
        load_cmd(0, OP_WRITE, 16'd0, 16'd888);
        load_cmd(1, OP_WRITE, 16'd1, 16'd111);
        load_cmd(2, OP_RCHK,  16'd0, 16'd888);
        load_cmd(3, OP_RCHK,  16'd1, 16'd999);
        run_b(4, 200, -1, cyc, acc, fst, dn);
        check_val("t1_cycles", cyc, 16);
        check_val("t1_first_strobe", fst, 1);
        check_val("t1_accesses", acc, 4);
        check_val("t1_done", dn, 1);
        check_val("t1_busy", busy_b, 0);
        check_val("t1_mis", mis_b, 1);
        check_val("t1_last", last_b, 111);
        @(negedge clk);
        check_val("t1_done_1cyc", done_b, 0);

        // Zero-length run: done next cycle, no bus activity.
        run_b(0, 10, -1, cyc, acc, fst, dn);
        check_val("c0_cycles", cyc, 0);
        check_val("c0_done", dn, 1);
        check_val("c0_strobes", {30'd0, rd_b, wr_b}, 0);
        @(negedge clk);
        check_val("c0_done_1cyc", done_b, 0);

        // Count above depth clamps to 32 accesses.
        for (int i = 0; i < 32; i++) load_cmd(i, OP_READ, 16'(i), 16'd0);
        run_b(40, 400, -1, cyc, acc, fst, dn);
        check_val("c40_accesses", acc, 32);
        check_val("c40_cycles", cyc, 128);
        check_val("c40_done", dn, 1);

        // start/cmd_we during a run are ignored; slot 3 must survive.
        load_cmd(0, OP_WRITE, 16'd10, 16'h1234);
        load_cmd(1, OP_RCHK,  16'd10, 16'h1234);
        load_cmd(2, OP_WRITE, 16'd11, 16'h00AA);
        load_cmd(3, OP_RCHK,  16'd11, 16'h00AA);
        run_b(4, 200, 5, cyc, acc, fst, dn);
        check_val("poke_cycles", cyc, 16);
        check_val("poke_mis", mis_b, 0);
        check_val("poke_last", last_b, 16'h00AA);
        @(negedge clk);
        run_b(4, 200, -1, cyc, acc, fst, dn);
        check_val("poke_rerun_mis", mis_b, 0);
        check_val("poke_rerun_cycles", cyc, 16);

        // Watchdog on the never-ready instance.
        load_cmd(0, OP_READ, 16'd1024, 16'd0);
        cmd_count = 6'd1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        rdc = 0;
        while (busy_a && cyc < 100) begin
            if (rd_a) rdc++;
            cyc++;
            @(negedge clk);
        end
        check_val("to_rd_cycles", rdc, 8);
        check_val("to_busy_cycles", cyc, 9);
        check_val("to_terr", terr_a, 1);
        check_val("to_done", done_a, 1);
        check_val("to_busy", busy_a, 0);
        check_val("to_rd_low", rd_a, 0);
        @(negedge clk);
        check_val("to_terr_sticky", terr_a, 1);

        // Reset in the middle of a write.
        load_cmd(0, OP_WRITE, 16'd2049, 16'd555);
        cmd_count = 6'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!wr_b && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("mid_wr_seen", wr_b, 1);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_wr", wr_b, 0);
        check_val("mid_rst_rd", rd_b, 0);
        check_val("mid_rst_busy", busy_b, 0);
        check_val("mid_rst_last", last_b, 0);
        check_val("mid_rst_mis", mis_b, 0);
        check_val("mid_rst_terr_a", terr_a, 0);
        repeat (2) begin
            @(negedge clk);
            check_val("mid_rst_no_done", done_b, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        load_cmd(0, OP_WRITE, 16'd0, 16'd888);
        load_cmd(1, OP_WRITE, 16'd1, 16'd111);
        load_cmd(2, OP_RCHK,  16'd0, 16'd888);
        load_cmd(3, OP_RCHK,  16'd1, 16'd999);
        run_b(4, 200, -1, cyc, acc, fst, dn);
        check_val("fresh_cycles", cyc, 16);
        check_val("fresh_mis", mis_b, 1);
        check_val("fresh_last", last_b, 111);

        // 100 random commands in 4 runs of 25, latency 1..20, scoreboarded.
        rand_lat = 1'b1;
        exp_last = last_b == 16'd111 ? 16'd111 : 16'd111;
        exp_last = 16'd111;
        for (int b = 0; b < 4; b++) begin
            exp_mis = 0;
            for (int i = 0; i < 25; i++) begin
                op_e         op;
                logic [15:0] adr, dat;
                dat = 16'($urandom);
                if (b == 0 && i < 16) begin
                    op  = OP_WRITE;
                    adr = 16'(48 + i);
                end else begin
                    op  = op_e'($urandom_range(3, 0));
                    adr = 16'(48 + $urandom_range(15, 0));
                end
                case (op)
                    OP_WRITE: model[adr[5:0]] = dat;
                    OP_READ:  exp_last = model[adr[5:0]];
                    OP_RCHK: begin
                        if ($urandom_range(1, 0) == 1) dat = model[adr[5:0]];
                        exp_last = model[adr[5:0]];
                        if (dat != model[adr[5:0]]) exp_mis++;
                    end
                    default: ;
                endcase
                load_cmd(i, op, adr, dat);
            end
            run_b(25, 3000, -1, cyc, acc, fst, dn);
            check_val($sformatf("rnd%0d_done", b), dn, 1);
            check_val($sformatf("rnd%0d_mis", b), mis_b, 32'(exp_mis));
            check_val($sformatf("rnd%0d_last", b), last_b, exp_last);
            @(negedge clk);
        end

        check_val("no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
